core_sequencer: RTL and testbench
=================================

// Module: core_sequencer
// PURPOSE
//  Multicycle sequencer for the RV32I core. Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB using control_unit decode outputs.
//  Handshakes with instruction and data memory, and drives PC/IR/RF write enables and PC select. Provides halt/run/single-step control, retire count and traps.
// PARAMETERS
//  RESET_RUN       1    1 = go to FETCH after reset; 0 = go to HALT
//  TIMEOUT_CYCLES  255  max wait cycles per memory request before trap; 0 = timeout disabled
// PORTS
//  clk_i           in   1   core clock
//  rst_i           in   1   reset, asynchronous, active-high
//  opcode_i        in   7   IR[6:0]
//  branch_i/jump_i/mem_read_i/mem_write_i/reg_write_i  in 1 each  from control_unit
//  branch_taken_i  in   1   datapath compare result, valid in EXECUTE
//  imem_ready_i    in   1   fetch data valid
//  dmem_ready_i    in   1   load data valid / store accepted
//  run_i, halt_i, step_i, trap_clr_i  in 1 each  run control
//  imem_req_o      out  1   fetch request
//  dmem_req_o      out  1   data request
//  dmem_we_o       out  1   1 = store
//  ir_we_o         out  1   latch instruction
//  rf_we_o         out  1   register file write
//  pc_we_o         out  1   PC update
//  pc_sel_o        out  2   00 PC+4, 01 PC+imm (taken branch/JAL), 10 ALU result (JALR)
//  retire_o        out  1   1-cycle pulse per committed instruction
//  retire_cnt_o    out  32  committed instruction count, wraps 2^32-1 -> 0
//  halted_o        out  1   in HALT
//  trap_o          out  1   in TRAP
//  trap_cause_o    out  2   00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout
// BEHAVIOUR
//  Reset: state = FETCH if RESET_RUN else HALT; retire_cnt 0; step/halt_pending 0; all outputs 0 except halted_o = !RESET_RUN.
//  All outputs are Moore/registered-state decodes; reset drops requests immediately.
//  HALT: halted_o=1. halt_i or halt_pending wins over run_i/step_i.
//    Otherwise step_i -> FETCH with step flag; run_i -> FETCH.
//  FETCH: imem_req_o held high until imem_ready_i. In the ready cycle ir_we_o=1 -> DECODE.
//  DECODE: one cycle. Opcode not among the 8 supported -> TRAP, cause 01. Else -> EXECUTE.
//  EXECUTE: one cycle. mem_read_i|mem_write_i -> MEM; else reg_write_i -> WB; else commit (branch).
//  MEM: dmem_req_o held high, dmem_we_o=mem_write_i stable, until dmem_ready_i. Load -> WB; store commits in the ready cycle.
//  WB: rf_we_o=1 for one cycle; commit.
//  Commit cycle: pc_we_o=1, retire_o=1, retire_cnt_o+1 on the next edge.
//    pc_sel: JALR (jump_i & !opcode_i[3]) = 10; JAL or (branch_i & branch_taken_i) = 01; else 00.
//  After commit: -> HALT if halt_pending, step flag or halt_i; else -> FETCH. Step flag and halt_pending clear on entering HALT.
//  halt_i mid-instruction sets halt_pending; it never aborts an instruction or drops a request.
//  Timeout: wait counter clears on entering FETCH/MEM and increments each cycle req=1 & ready=0.
//    When it reaches TIMEOUT_CYCLES (nonzero) -> TRAP, cause 10 or 11; no commit.
//  TRAP: trap_o=1, cause held, every enable 0. Ignores run/step/halt. trap_clr_i -> HALT, cause 00.
//  Latency with zero-wait memory (ready in the request cycle): R/I/LUI/JAL/JALR 4 cycles, load 5, store 4, branch 3.
//  Async reset mid-MEM/FETCH: request and enables deassert without waiting for the clock. No partial commit.
// STRUCTURE
//  core_pkg: opcode localparams (shared with control_unit), seq_state_e {HALT,FETCH,DECODE,EXECUTE,MEM,WB,TRAP}, trap_cause_e, pc_sel_e.
//  Sub-module wait_timer: clear/enable counter, width $clog2(TIMEOUT_CYCLES+1), expired flag.
//  FSM, output decode and retire counter live in core_sequencer.
// TESTING
//  1. RESET_RUN=1, zero-wait imem, opcode 0110011, reg_write=1 -> imem_req+ir_we cycle 1; rf_we+pc_we, pc_sel=00, retire cycle 4; retire_cnt=1.
//  2. LW, dmem_ready 3 cycles late -> dmem_req high 4 cycles, dmem_we=0, one rf_we pulse; commit cycle 8.
//  3. BEQ taken / not taken -> commit in cycle 3, pc_sel=01 / 00, rf_we never; JALR -> pc_sel=10, rf_we=1.
//  4. Opcode 0000000 -> trap_o=1, cause=01 after DECODE, no pc_we; trap_clr_i -> halted_o=1, cause=00.
//  5. halt_i pulse during SW MEM wait -> store completes, retire, then HALT. step_i -> exactly one retire, then HALT. halt_i+run_i together in HALT -> stays HALT.
//  6. imem_ready never, TIMEOUT_CYCLES=4 -> TRAP cause 10 after 4 wait cycles; rst_i mid-MEM -> dmem_req 0 immediately, retire_cnt 0.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
//==============================================================================
// Module      : core_pkg
// Description : Shared RV32I opcodes, sequencer state codes, trap causes and
//               PC-select encodings.
// Revision    : 1.0
//==============================================================================
package core_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_HALT    = 3'd0;
    localparam seq_state_t ST_FETCH   = 3'd1;
    localparam seq_state_t ST_DECODE  = 3'd2;
    localparam seq_state_t ST_EXECUTE = 3'd3;
    localparam seq_state_t ST_MEM     = 3'd4;
    localparam seq_state_t ST_WB      = 3'd5;
    localparam seq_state_t ST_TRAP    = 3'd6;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_IMEM_TO = 2'b10,
        CAUSE_DMEM_TO = 2'b11
    } trap_cause_e;

    typedef enum logic [1:0] {
        PC_SEL_PLUS4 = 2'b00,
        PC_SEL_IMM   = 2'b01,
        PC_SEL_ALU   = 2'b10
    } pc_sel_e;

    function automatic logic is_supported_opcode(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_JAL,
            OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/wait_timer.sv
`default_nettype none
//==============================================================================
// Module      : wait_timer
// Description : Counts memory wait cycles; flags the cycle in which the wait
//               count reaches TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 disables it.
// Revision    : 1.0
//==============================================================================
module wait_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            logic unused_inputs;
            assign unused_inputs = &{1'b0, clk_i, rst_i, clear_i, en_i};
            assign expired_o     = 1'b0;
        end else begin : g_enabled
            localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clear_i) begin
                    cnt_d = '0;
                end else if (en_i && (cnt_q != LAST_WAIT)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // Expires in the wait cycle that makes the count equal TIMEOUT_CYCLES.
            assign expired_o = en_i && (cnt_q == LAST_WAIT);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
//==============================================================================
// Module      : core_sequencer
// Description : Multicycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/WB with
//               run/halt/step control, retire counter and trap handling.
// Revision    : 1.0
//==============================================================================
module core_sequencer
    import core_pkg::*;
#(
    parameter bit RESET_RUN      = 1'b1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [6:0]  opcode_i,
    input  logic        branch_i,
    input  logic        jump_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic        reg_write_i,
    input  logic        branch_taken_i,
    input  logic        imem_ready_i,
    input  logic        dmem_ready_i,
    input  logic        run_i,
    input  logic        halt_i,
    input  logic        step_i,
    input  logic        trap_clr_i,
    output logic        imem_req_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic        ir_we_o,
    output logic        rf_we_o,
    output logic        pc_we_o,
    output logic [1:0]  pc_sel_o,
    output logic        retire_o,
    output logic [31:0] retire_cnt_o,
    output logic        halted_o,
    output logic        trap_o,
    output logic [1:0]  trap_cause_o
);

    localparam seq_state_t RESET_STATE = RESET_RUN ? ST_FETCH : ST_HALT;

    seq_state_t  state_q, state_d;
    logic        halt_pending_q, halt_pending_d;
    logic        step_q, step_d;
    trap_cause_e cause_q, cause_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;

    logic    imem_req;
    logic    dmem_req;
    logic    dmem_we;
    logic    ir_we;
    logic    rf_we;
    logic    commit;
    pc_sel_e pc_sel;

    logic wait_en;
    logic wait_clear;
    logic wait_expired;

    assign wait_en    = ((state_q == ST_FETCH) && !imem_ready_i) ||
                        ((state_q == ST_MEM)   && !dmem_ready_i);
    assign wait_clear = (state_d != state_q);

    wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (wait_clear),
        .en_i      (wait_en),
        .expired_o (wait_expired)
    );

    always_comb begin
        state_d        = state_q;
        halt_pending_d = halt_pending_q;
        step_d         = step_q;
        cause_d        = cause_q;
        imem_req       = 1'b0;
        dmem_req       = 1'b0;
        dmem_we        = 1'b0;
        ir_we          = 1'b0;
        rf_we          = 1'b0;
        commit         = 1'b0;
        pc_sel         = PC_SEL_PLUS4;

        // A halt request mid-instruction is remembered, never acted on early.
        if (halt_i && (state_q != ST_HALT) && (state_q != ST_TRAP)) begin
            halt_pending_d = 1'b1;
        end

        case (state_q)
            ST_HALT: begin
                if (halt_i || halt_pending_q) begin
                    state_d = ST_HALT;
                end else if (step_i) begin
                    state_d = ST_FETCH;
                    step_d  = 1'b1;
                end else if (run_i) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready_i) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_IMEM_TO;
                end
            end
            ST_DECODE: begin
                if (!is_supported_opcode(opcode_i)) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (mem_read_i || mem_write_i) begin
                    state_d = ST_MEM;
                end else if (reg_write_i) begin
                    state_d = ST_WB;
                end else begin
                    commit = 1'b1;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_write_i;
                if (dmem_ready_i) begin
                    if (mem_read_i) begin
                        state_d = ST_WB;
                    end else begin
                        commit = 1'b1;
                    end
                end else if (wait_expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_DMEM_TO;
                end
            end
            ST_WB: begin
                rf_we  = 1'b1;
                commit = 1'b1;
            end
            ST_TRAP: begin
                if (trap_clr_i) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_NONE;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase

        if (commit) begin
            if (jump_i && !opcode_i[3]) begin
                pc_sel = PC_SEL_ALU;
            end else if ((jump_i && opcode_i[3]) || (branch_i && branch_taken_i)) begin
                pc_sel = PC_SEL_IMM;
            end
            state_d = (halt_pending_q || step_q || halt_i) ? ST_HALT : ST_FETCH;
        end

        if ((state_d == ST_HALT) && (state_q != ST_HALT)) begin
            halt_pending_d = 1'b0;
            step_d         = 1'b0;
        end

        retire_cnt_d = retire_cnt_q + {31'd0, commit};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= RESET_STATE;
            halt_pending_q <= 1'b0;
            step_q         <= 1'b0;
            cause_q        <= CAUSE_NONE;
            retire_cnt_q   <= 32'd0;
        end else begin
            state_q        <= state_d;
            halt_pending_q <= halt_pending_d;
            step_q         <= step_d;
            cause_q        <= cause_d;
            retire_cnt_q   <= retire_cnt_d;
        end
    end

    // Reset forces every request and enable low without waiting for a clock edge.
    assign imem_req_o   = imem_req & ~rst_i;
    assign dmem_req_o   = dmem_req & ~rst_i;
    assign dmem_we_o    = dmem_we & ~rst_i;
    assign ir_we_o      = ir_we & ~rst_i;
    assign rf_we_o      = rf_we & ~rst_i;
    assign pc_we_o      = commit & ~rst_i;
    assign retire_o     = commit & ~rst_i;
    assign pc_sel_o     = rst_i ? 2'b00 : pc_sel;
    assign retire_cnt_o = retire_cnt_q;
    assign halted_o     = (state_q == ST_HALT);
    assign trap_o       = (state_q == ST_TRAP);
    assign trap_cause_o = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
//==============================================================================
// Module      : tb_core_sequencer
// Description : Randomized instruction-level checking of core_sequencer.
// Revision    : 1.0
//==============================================================================
module tb_core_sequencer;

    localparam int TO = 4;

    localparam int K_R    = 0;
    localparam int K_I    = 1;
    localparam int K_LUI  = 2;
    localparam int K_JAL  = 3;
    localparam int K_JALR = 4;
    localparam int K_LD   = 5;
    localparam int K_ST   = 6;
    localparam int K_BR   = 7;
    localparam int K_BAD  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode_i;
    logic        branch_i, jump_i, mem_read_i, mem_write_i, reg_write_i;
    logic        branch_taken_i, imem_ready_i, dmem_ready_i;
    logic        run_i, halt_i, step_i, trap_clr_i;
    logic        imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, rf_we_o, pc_we_o;
    logic [1:0]  pc_sel_o;
    logic        retire_o;
    logic [31:0] retire_cnt_o;
    logic        halted_o, trap_o;
    logic [1:0]  trap_cause_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] model_cnt;
    logic [6:0]  bad_opc;
    logic [44:0] obs;

    always #5 clk = ~clk;

    core_sequencer #(
        .RESET_RUN      (1'b1),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .opcode_i       (opcode_i),
        .branch_i       (branch_i),
        .jump_i         (jump_i),
        .mem_read_i     (mem_read_i),
        .mem_write_i    (mem_write_i),
        .reg_write_i    (reg_write_i),
        .branch_taken_i (branch_taken_i),
        .imem_ready_i   (imem_ready_i),
        .dmem_ready_i   (dmem_ready_i),
        .run_i          (run_i),
        .halt_i         (halt_i),
        .step_i         (step_i),
        .trap_clr_i     (trap_clr_i),
        .imem_req_o     (imem_req_o),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .ir_we_o        (ir_we_o),
        .rf_we_o        (rf_we_o),
        .pc_we_o        (pc_we_o),
        .pc_sel_o       (pc_sel_o),
        .retire_o       (retire_o),
        .retire_cnt_o   (retire_cnt_o),
        .halted_o       (halted_o),
        .trap_o         (trap_o),
        .trap_cause_o   (trap_cause_o)
    );

    assign obs = {retire_cnt_o, imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, rf_we_o,
                  pc_we_o, pc_sel_o, retire_o, halted_o, trap_o, trap_cause_o};

    function automatic logic [44:0] mk(input logic [31:0] cnt, input logic ireq, input logic dreq,
                                       input logic dwe, input logic irwe, input logic rfwe,
                                       input logic pcwe, input logic [1:0] sel, input logic ret,
                                       input logic hlt, input logic trp, input logic [1:0] cause);
        return {cnt, ireq, dreq, dwe, irwe, rfwe, pcwe, sel, ret, hlt, trp, cause};
    endfunction

    function automatic logic [44:0] halt_vec();
        return mk(model_cnt, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 2'b00);
    endfunction

    function automatic logic [44:0] trap_vec(input logic [1:0] cause);
        return mk(model_cnt, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, cause);
    endfunction

    task automatic check_val(input string tag, input logic [44:0] got, input logic [44:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int pick_delay();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) return r % 3;
        if (r < 9) return TO - 1;
        return int'($urandom_range(TO, TO + 2));
    endfunction

    task automatic set_ctrl(input int kind);
        {branch_i, jump_i, mem_read_i, mem_write_i, reg_write_i} = 5'b0;
        case (kind)
            K_R:    begin opcode_i = 7'b0110011; reg_write_i = 1'b1; end
            K_I:    begin opcode_i = 7'b0010011; reg_write_i = 1'b1; end
            K_LUI:  begin opcode_i = 7'b0110111; reg_write_i = 1'b1; end
            K_JAL:  begin opcode_i = 7'b1101111; jump_i = 1'b1; reg_write_i = 1'b1; end
            K_JALR: begin opcode_i = 7'b1100111; jump_i = 1'b1; reg_write_i = 1'b1; end
            K_LD:   begin opcode_i = 7'b0000011; mem_read_i = 1'b1; reg_write_i = 1'b1; end
            K_ST:   begin opcode_i = 7'b0100011; mem_write_i = 1'b1; end
            K_BR:   begin opcode_i = 7'b1100011; branch_i = 1'b1; end
            default: begin
                opcode_i = bad_opc;
                {branch_i, jump_i, mem_read_i, mem_write_i, reg_write_i} = 5'($urandom);
            end
        endcase
    endtask

    // Entered and left 1 time unit after a rising edge; one loop pass per clock cycle.
    task automatic run_instr(input int kind, input int idly, input int ddly, input bit taken,
                             input int halt_at, input bit stepping,
                             output int res, output logic [1:0] cause);
        int         f, l, m_start, m_end;
        bit         is_mem, has_wb, commit, in_mem;
        logic [1:0] sel, tc;
        set_ctrl(kind);
        branch_taken_i = (kind == K_BR) ? taken : 1'($urandom);
        is_mem  = (kind == K_LD) || (kind == K_ST);
        has_wb  = !((kind == K_ST) || (kind == K_BR));
        f       = idly + 1;
        m_start = f + 3;
        m_end   = f + 3 + ddly;
        if (idly >= TO) begin
            l = TO; tc = 2'b10;
        end else if (kind == K_BAD) begin
            l = f + 1; tc = 2'b01;
        end else if (is_mem && ddly >= TO) begin
            l = f + 2 + TO; tc = 2'b11;
        end else begin
            l  = is_mem ? m_end : f + 2;
            l += has_wb ? 1 : 0;
            tc = 2'b00;
        end
        sel = (kind == K_JALR) ? 2'b10 :
              ((kind == K_JAL) || (kind == K_BR && taken)) ? 2'b01 : 2'b00;
        for (int c = 1; c <= l; c++) begin
            imem_ready_i = (c == f);
            dmem_ready_i = is_mem && (c == m_end);
            halt_i       = (c == halt_at);
            commit       = (tc == 2'b00) && (c == l);
            in_mem       = is_mem && (c >= m_start) && (c <= m_end);
            #3;
            check_val($sformatf("instr k%0d i%0d d%0d c%0d", kind, idly, ddly, c), obs,
                      mk(model_cnt, c <= f, in_mem, in_mem && kind == K_ST, c == f,
                         commit && has_wb, commit, commit ? sel : 2'b00, commit, 0, 0, 2'b00));
            @(posedge clk);
            #1;
        end
        imem_ready_i = 1'b0;
        dmem_ready_i = 1'b0;
        halt_i       = 1'b0;
        if (tc == 2'b00) model_cnt++;
        if (tc != 2'b00)                                        res = 2;
        else if (stepping || (halt_at >= 1 && halt_at <= l))   res = 1;
        else                                                    res = 0;
        cause = tc;
    endtask

    task automatic idle_cycle(input logic r, input logic h, input logic s, input logic clr,
                              input logic [44:0] exp, input string tag);
        run_i = r; halt_i = h; step_i = s; trap_clr_i = clr;
        #3;
        check_val(tag, obs, exp);
        @(posedge clk);
        #1;
        run_i = 1'b0; halt_i = 1'b0; step_i = 1'b0; trap_clr_i = 1'b0;
    endtask

    task automatic resume(input int mode, input logic [1:0] cause);
        if (mode == 2) idle_cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'b1,
                                  trap_vec(cause), "trap clear");
        if (mode >= 1) idle_cycle(1'b1, 1'b0, 1'b0, 1'b0, halt_vec(), "halt run");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         res, mode, kind;
        logic [1:0] cause, last_cause;
        bit         step_mode;
        logic       r, h, s;

        rst = 1'b1;
        {opcode_i, branch_i, jump_i, mem_read_i, mem_write_i, reg_write_i} = '0;
        {branch_taken_i, imem_ready_i, dmem_ready_i} = '0;
        {run_i, halt_i, step_i, trap_clr_i} = '0;
        bad_opc   = 7'b0000000;
        model_cnt = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        imem_ready_i = 1'b1;
        #3;
        check_val("reset", obs, mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00));
        imem_ready_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed instruction mix with zero and non-zero wait states.
        run_instr(K_R,    0, 0, 0, 0, 0, res, cause);
        run_instr(K_LD,   0, 3, 0, 0, 0, res, cause);
        run_instr(K_BR,   0, 0, 1, 0, 0, res, cause);
        run_instr(K_BR,   0, 0, 0, 0, 0, res, cause);
        run_instr(K_JALR, 0, 0, 0, 0, 0, res, cause);
        run_instr(K_JAL,  1, 0, 0, 0, 0, res, cause);
        run_instr(K_ST,   1, 2, 0, 0, 0, res, cause);
        run_instr(K_LUI,  0, 0, 0, 0, 0, res, cause);
        run_instr(K_I,    2, 0, 0, 0, 0, res, cause);

        // Illegal opcode, then trap clear, halt/run priority, single step.
        bad_opc = 7'b0000000;
        run_instr(K_BAD, 0, 0, 0, 0, 0, res, cause);
        idle_cycle(1, 1, 1, 0, trap_vec(2'b01), "trap hold");
        idle_cycle(1, 1, 1, 1, trap_vec(2'b01), "trap clear");
        idle_cycle(1, 1, 0, 0, halt_vec(), "halt+run");
        idle_cycle(0, 0, 1, 0, halt_vec(), "halt step");
        run_instr(K_R, 0, 0, 0, 0, 1, res, cause);
        idle_cycle(1, 0, 0, 0, halt_vec(), "after step");

        // Halt request during a store memory wait.
        run_instr(K_ST, 0, 3, 0, 5, 0, res, cause);
        idle_cycle(1, 0, 0, 0, halt_vec(), "after halted store");

        // Fetch and data timeouts.
        run_instr(K_R, TO + 2, 0, 0, 0, 0, res, cause);
        resume(2, 2'b10);
        run_instr(K_LD, 0, TO, 0, 0, 0, res, cause);
        resume(2, 2'b11);

        mode = 0; step_mode = 0; last_cause = 2'b00;
        for (int i = 0; i < 150; i++) begin
            if (mode == 2) begin
                idle_cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'b1,
                           trap_vec(last_cause), "rand trap clear");
                mode = 1;
            end else if (mode == 1) begin
                r = 1'($urandom);
                h = ($urandom_range(0, 3) == 0);
                s = 1'($urandom);
                idle_cycle(r, h, s, 1'b0, halt_vec(), "rand halt");
                if (!h && (r || s)) begin
                    mode      = 0;
                    step_mode = s;
                end
            end else begin
                kind    = int'($urandom_range(0, 8));
                bad_opc = ($urandom_range(0, 1) == 0) ? 7'b0010111 : 7'b1110011;
                run_instr(kind, pick_delay(), pick_delay(), 1'($urandom),
                          ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 8)) : 0,
                          step_mode, res, cause);
                mode = res;
                if (res == 2) last_cause = cause;
                if (res != 0) step_mode = 0;
            end
        end
        resume(mode, last_cause);

        // Asynchronous reset in the middle of a load's memory wait.
        set_ctrl(K_LD);
        for (int c = 1; c <= 3; c++) begin
            imem_ready_i = (c == 1);
            @(posedge clk);
            #1;
        end
        imem_ready_i = 1'b0;
        dmem_ready_i = 1'b0;
        #1;
        check_val("mem wait", obs, mk(model_cnt, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00));
        rst = 1'b1;
        #1;
        check_val("async reset", obs, mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_cnt = 32'd0;
        run_instr(K_JAL, 0, 0, 0, 0, 0, res, cause);
        #3;
        check_val("post reset", obs, mk(model_cnt, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
